// File: rtl/ascii_pkg.sv
// Shared ASCII constants, parser state encoding and character-class helpers
// used by the decimal receive parser and the decimal print path.
package ascii_pkg;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } parse_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CHAR_0) && (c <= CHAR_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CHAR_LF) || (c == CHAR_CR);
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return c == CHAR_SP;
    endfunction

endpackage

// File: rtl/ascii_dec_parser_mac.sv
// Combinational decimal multiply-accumulate: sum = acc*10 + digit, with an
// overflow flag when the result no longer fits in WIDTH bits.
module dec_mac #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam int unsigned EXT_W = WIDTH + 4;

    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] ext;

    // *10 as shift-and-add; 4 guard bits hold the worst case (2^W-1)*10+9
    always_comb begin
        acc_ext = {4'b0000, acc};
        ext     = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit);
        sum     = ext[WIDTH-1:0];
        ovf     = |ext[EXT_W-1:WIDTH];
    end

endmodule

// File: rtl/ascii_dec_parser.sv
// Parses an unsigned decimal number from a UART byte stream, terminated by
// CR or LF; emits the value with a one-cycle valid pulse or an error pulse.
module ascii_dec_parser
    import ascii_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             error,
    output logic             busy
);

    parse_state_e     state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q;

    logic [WIDTH-1:0] mac_sum;
    logic             mac_ovf;
    logic             c_digit, c_term, c_space;

    dec_mac #(
        .WIDTH (WIDTH)
    ) u_dec_mac (
        .acc   (acc_q),
        .digit (rx_data[3:0]),
        .sum   (mac_sum),
        .ovf   (mac_ovf)
    );

    assign c_digit = is_digit(rx_data);
    assign c_term  = is_term(rx_data);
    assign c_space = is_space(rx_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state and datapath updates; nothing moves without a strobe
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        if (new_rx_data) begin
            case (state_q)
                IDLE: begin
                    if (c_digit) begin
                        acc_d   = WIDTH'(rx_data[3:0]);
                        state_d = ACCUM;
                    end else if (!(c_space || c_term)) begin
                        state_d = DISCARD;
                    end
                end
                ACCUM: begin
                    if (c_digit) begin
                        if (mac_ovf) begin
                            state_d = DISCARD;
                        end else begin
                            acc_d = mac_sum;
                        end
                    end else if (c_term) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (c_term) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign error       = error_q;
    assign busy        = busy_q;

endmodule
